md_tx_byte_packer: RTL and testbench

- Downstream consumer of the aligner's MD TX port.
- Accepts MD TX transfers (data/offset/size), checks legality, extracts the valid bytes, and pushes them into an internal byte FIFO.
- Repacks the bytes into full DW-wide words on a valid/ready output stream.
- Supports a flush that drains a trailing partial word. Error and byte counters are exposed for the APB status path.

---
 rtl/md_tx_byte_packer.sv | 138 +++++++++++++
 tb/tb_md_tx_byte_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_tx_byte_packer.sv
// Purpose: accept MD TX transfers, drop illegal ones, buffer the valid bytes and repack them into DW-wide words.
// Latency: a legal transfer that completes a word shows out_valid on the next cycle.
// Backpressure: md_tx_ready falls when fewer than NB bytes are free or a flush is draining; output holds under !out_ready.
module md_tx_byte_packer #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          md_tx_valid,
  input  logic [DW-1:0] md_tx_data,
  input  logic [1:0]    md_tx_offset,
  input  logic [2:0]    md_tx_size,
  output logic          md_tx_ready,
  output logic          md_tx_err,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_nbytes,
  input  logic          out_ready,
  output logic [CW-1:0] byte_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam int NB = DW / 8;
  localparam int AW = $clog2(DEPTH);

  // Occupancy is one bit wider than the pointers so a completely full FIFO is representable.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] NB_C    = (AW+1)'(NB);
  localparam logic [2:0]  NB_N    = 3'(NB);

  // Byte storage; contents are only meaningful between rptr and wptr, so it carries no reset.
  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          flush_pend;
  logic          flush_pend_nxt;
  // Keeps md_tx_ready low while reset is asserted even though the empty FIFO would otherwise look ready.
  logic          out_of_reset;

  logic          size_ok;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic [DW-1:0] shifted;
  logic [AW:0]   space;
  logic [AW:0]   push_n;
  logic [AW:0]   pop_n;
  logic          full_word;
  logic          part_word;

  // Input side: legality, handshake and byte alignment of the incoming transfer.
  always_comb begin
    size_ok     = (md_tx_size == 3'd1) || (md_tx_size == 3'd2) || (md_tx_size == 3'd4);
    legal       = size_ok && (({2'b00, md_tx_offset} + {1'b0, md_tx_size}) <= 4'(NB));
    space       = DEPTH_C - count;
    md_tx_ready = out_of_reset && !flush_pend && (space >= NB_C);
    accept      = md_tx_valid && md_tx_ready;
    push        = accept && legal;
    md_tx_err   = accept && !legal;
    // Shift the first valid byte down to lane 0 so lane k is written at wptr+k.
    shifted     = md_tx_data >> {md_tx_offset, 3'b000};
    push_n      = push ? (AW+1)'(md_tx_size) : '0;
  end

  // Output side: a full word whenever one is buffered, otherwise a partial word only while flushing.
  always_comb begin
    full_word  = (count >= NB_C);
    part_word  = flush_pend && (count != '0) && !full_word;
    out_valid  = full_word || part_word;
    out_nbytes = full_word ? NB_N : (part_word ? count[2:0] : 3'd0);
    out_data   = '0;
    // Lanes beyond out_nbytes read as zero, which also keeps out_data at zero when idle.
    for (int i = 0; i < NB; i++) begin
      if (3'(i) < out_nbytes) begin
        out_data[8*i +: 8] = mem[rptr + AW'(i)];
      end
    end
    pop   = out_valid && out_ready;
    pop_n = pop ? (AW+1)'(out_nbytes) : '0;
  end

  // Next occupancy and flush state; a flush that would leave the FIFO empty never holds ready low.
  always_comb begin
    count_nxt      = count + push_n - pop_n;
    flush_pend_nxt = (flush_pend || flush) && (count_nxt != '0);
  end

  // Write the accepted bytes at consecutive addresses; the pointer sum wraps naturally.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < NB; k++) begin
        if (3'(k) < md_tx_size) begin
          mem[wptr + AW'(k)] <= shifted[8*k +: 8];
        end
      end
    end
  end

  // Pointers, occupancy and flush tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      flush_pend   <= 1'b0;
      out_of_reset <= 1'b0;
    end else begin
      wptr         <= wptr + push_n[AW-1:0];
      rptr         <= rptr + pop_n[AW-1:0];
      count        <= count_nxt;
      flush_pend   <= flush_pend_nxt;
      out_of_reset <= 1'b1;
    end
  end

  // Status counters: bytes pushed wrap, illegal transfers saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (push) begin
        byte_cnt <= byte_cnt + CW'(md_tx_size);
      end
      if (md_tx_err && (err_cnt != {CW{1'b1}})) begin
        err_cnt <= err_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_md_tx_byte_packer.sv
// Directed bench for md_tx_byte_packer with a byte-queue scoreboard.
// Stimulus is driven 1 time unit after the rising edge; the DUT is observed on the falling edge.
module tb_md_tx_byte_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_tx_valid;
  logic [31:0] md_tx_data;
  logic [1:0]  md_tx_offset;
  logic [2:0]  md_tx_size;
  logic        md_tx_ready;
  logic        md_tx_err;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
  logic        out_ready;
  logic [15:0] byte_cnt;
  logic [15:0] err_cnt;

  int passed = 0;
  int total  = 0;

  // Scoreboard state: bytes expected at the output, in order.
  logic [7:0]  sb [$];
  logic        mdl_fpend = 1'b0;
  logic        mon_en    = 1'b0;
  logic        tog_en    = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_nb;

  md_tx_byte_packer #(.DW(32), .DEPTH(16), .CW(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_tx_valid  (md_tx_valid),
    .md_tx_data   (md_tx_data),
    .md_tx_offset (md_tx_offset),
    .md_tx_size   (md_tx_size),
    .md_tx_ready  (md_tx_ready),
    .md_tx_err    (md_tx_err),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_nbytes   (out_nbytes),
    .out_ready    (out_ready),
    .byte_cnt     (byte_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one transfer and hold it until accepted; returns md_tx_err seen on the accept cycle.
  task automatic send(input int off, input int sz, input logic [31:0] dat, output logic err);
    logic done;
    done = 1'b0;
    err  = 1'b0;
    md_tx_valid  = 1'b1;
    md_tx_offset = 2'(off);
    md_tx_size   = 3'(sz);
    md_tx_data   = dat;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (md_tx_ready) begin
        done = 1'b1;
        err  = md_tx_err;
      end
      @(posedge clk);
      #1;
    end
    md_tx_valid = 1'b0;
    check("send_accepted", done, 1'b1);
  endtask

  // Scoreboard monitor: predicts ready/valid, checks every popped word and every accept.
  always @(negedge clk) begin
    int          exp_nb;
    logic [31:0] exp_word;
    int          off;
    int          sz;
    logic        legal;
    if (reset_n && mon_en) begin
      check("mon_out_valid", out_valid, (sb.size() >= 4) || (mdl_fpend && sb.size() > 0));
      check("mon_tx_ready", md_tx_ready, (sb.size() <= 12) && !mdl_fpend);
      if (stall_prev) begin
        check("hold_data", out_data, prev_data);
        check("hold_nbytes", out_nbytes, prev_nb);
      end
      if (out_valid && out_ready) begin
        exp_nb   = (sb.size() >= 4) ? 4 : sb.size();
        exp_word = '0;
        check("sb_nbytes", out_nbytes, exp_nb);
        for (int k = 0; k < exp_nb; k++) exp_word[8*k +: 8] = sb.pop_front();
        check("sb_data", out_data, exp_word);
      end
      if (md_tx_valid && md_tx_ready) begin
        off   = md_tx_offset;
        sz    = md_tx_size;
        legal = (sz == 1 || sz == 2 || sz == 4) && (off + sz <= 4);
        check("sb_tx_err", md_tx_err, !legal);
        if (legal) begin
          for (int k = 0; k < sz; k++) sb.push_back(md_tx_data[8*(off+k) +: 8]);
        end
      end
      mdl_fpend  = (mdl_fpend || flush) && (sb.size() != 0);
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_nb    = out_nbytes;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Toggles out_ready every cycle during the streaming phase.
  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      out_ready = ~out_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic        drained;
    logic [31:0] bp_word [5];
    int          sum;
    int          sz;
    int          off;

    reset_n      = 1'b0;
    md_tx_valid  = 1'b0;
    md_tx_data   = '0;
    md_tx_offset = '0;
    md_tx_size   = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", md_tx_ready, 1'b0);
    check("rst_tx_err", md_tx_err, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_nbytes", out_nbytes, 3'd0);
    check("rst_byte_cnt", byte_cnt, 16'h0);
    check("rst_err_cnt", err_cnt, 16'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_tx_ready", md_tx_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);
    mon_en    = 1'b1;
    out_ready = 1'b1;

    // Single byte packing.
    send(0, 1, 32'h000000AA, e);
    send(1, 1, 32'h0000BB00, e);
    send(2, 1, 32'h00CC0000, e);
    send(3, 1, 32'hDD000000, e);
    check("pack_valid", out_valid, 1'b1);
    check("pack_data", out_data, 32'hDDCCBBAA);
    check("pack_nbytes", out_nbytes, 3'd4);
    check("pack_byte_cnt", byte_cnt, 16'd4);
    @(posedge clk);
    #1;

    // Illegal transfers.
    send(3, 2, 32'h12345678, e);
    check("illegal_err_a", e, 1'b1);
    send(0, 3, 32'h9ABCDEF0, e);
    check("illegal_err_b", e, 1'b1);
    check("illegal_err_cnt", err_cnt, 16'd2);
    check("illegal_byte_cnt", byte_cnt, 16'd4);
    check("illegal_out_valid", out_valid, 1'b0);

    // Backpressure and full.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) bp_word[i] = 32'hA0A1A2A3 + 32'(i * 32'h01010101);
    for (int i = 0; i < 4; i++) send(0, 4, bp_word[i], e);
    check("full_tx_ready", md_tx_ready, 1'b0);
    md_tx_valid  = 1'b1;
    md_tx_offset = 2'd0;
    md_tx_size   = 3'd4;
    md_tx_data   = bp_word[4];
    repeat (3) begin
      @(negedge clk);
      check("stall_tx_ready", md_tx_ready, 1'b0);
      check("stall_tx_err", md_tx_err, 1'b0);
      check("stall_head", out_data, bp_word[0]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready_pre", md_tx_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_ready_next", md_tx_ready, 1'b1);
    @(posedge clk);
    #1;
    md_tx_valid = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 50 && !drained; c++) begin
      @(negedge clk);
      #1;
      drained = !out_valid && (sb.size() == 0);
    end
    check("bp_drained", drained, 1'b1);
    @(posedge clk);
    #1;

    // Flush of a partial word.
    out_ready = 1'b0;
    send(1, 2, 32'h00343200, e);
    check("flush_push_err", e, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", out_valid, 1'b1);
    check("flush_data", out_data, 32'h00003432);
    check("flush_nbytes", out_nbytes, 3'd2);
    check("flush_tx_ready", md_tx_ready, 1'b0);
    @(posedge clk);
    #1;
    check("flush_hold_ready", md_tx_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_done_valid", out_valid, 1'b0);
    check("flush_done_ready", md_tx_ready, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_empty_ready", md_tx_ready, 1'b1);
    check("flush_empty_valid", out_valid, 1'b0);

    // Concurrent push/pop with pointer wrap.
    tog_en = 1'b1;
    sum = 0;
    for (int n = 0; n < 40; n++) begin
      sz  = 1 << $urandom_range(0, 2);
      off = $urandom_range(0, 4 - sz);
      send(off, sz, $urandom, e);
      check("stream_err", e, 1'b0);
      sum += sz;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      @(negedge clk);
      #1;
      drained = !out_valid && (sb.size() == 0);
    end
    tog_en = 1'b0;
    check("stream_drained", drained, 1'b1);
    check("stream_byte_cnt", byte_cnt, 16'(4 + 20 + 2 + sum));
    check("stream_err_cnt", err_cnt, 16'd2);
    check("stream_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
